// File: rtl/bp_table_arbiter.sv
// bp_table_arbiter: shares one single-port PHT between prediction lookups and queued training updates; owns GHR and the post-reset init sweep.
// Latency: lookup grant is combinational (lk_ready), prediction one cycle later; each update costs a read cycle plus a write cycle.
// Backpressure: lk_ready withheld during init, update write and forced update reads; up_ready low during init or while the queue is full.
module bp_table_arbiter #(
  parameter int IDX_W      = 6,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lk_valid,
  input  logic [31:0]      lk_pc,
  output logic             lk_ready,
  output logic             rsp_valid,
  output logic             rsp_taken,
  input  logic             up_valid,
  input  logic [31:0]      up_pc,
  input  logic             up_taken,
  output logic             up_ready,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [1:0]       tbl_wdata,
  input  logic [1:0]       tbl_rdata
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]    Q_FULL   = CW'(QDEPTH);
  localparam logic [SW-1:0]    S_LIM    = SW'(STARVE_MAX);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {ST_INIT, ST_ARB, ST_UPD_WR} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] init_cnt;
  logic [IDX_W-1:0] ghr;
  upd_t             queue [QDEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt;
  upd_t             held;
  upd_t             head;
  logic             rsp_vld_q;

  logic             q_empty, q_full;
  logic             push, pop, grant;
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [1:0]       sat_val;
  logic             en_c, we_c;
  logic [IDX_W-1:0] addr_c;
  logic [1:0]       wdata_c;

  // Only the index bits of the PCs feed the hash; the rest is intentionally dropped.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[31:IDX_W+2], lk_pc[1:0], up_pc[31:IDX_W+2], up_pc[1:0]};

  assign q_empty  = (count == '0);
  assign q_full   = (count == Q_FULL);
  assign head     = queue[rd_ptr];
  assign lk_idx   = lk_pc[IDX_W+1:2] ^ ghr;
  assign up_idx   = up_pc[IDX_W+1:2] ^ ghr;

  // up_ready looks only at the registered count, so a full queue refuses a push even on a pop cycle.
  assign up_ready = (state != ST_INIT) && !q_full;
  assign push     = up_valid && up_ready;

  // Update reads win when nothing else wants the port, when lookups have had their run, or when the queue is full.
  assign pop      = (state == ST_ARB) && !q_empty && (!lk_valid || (starve_cnt == S_LIM) || q_full);
  assign grant    = (state == ST_ARB) && !pop && lk_valid;
  assign lk_ready = grant;

  assign rsp_valid = rsp_vld_q;
  assign rsp_taken = rsp_vld_q & tbl_rdata[1];

  // SRAM controls are gated by rst_n so a write in flight is cut the moment reset asserts.
  assign tbl_en    = en_c & rst_n;
  assign tbl_we    = we_c & rst_n;
  assign tbl_addr  = addr_c & {IDX_W{rst_n}};
  assign tbl_wdata = wdata_c & {2{rst_n}};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  // Next-state: sweep the table once, then alternate between arbitration and update writes.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:   if (init_cnt == IDX_LAST) state_nxt = ST_ARB;
      ST_ARB:    if (pop) state_nxt = ST_UPD_WR;
      ST_UPD_WR: state_nxt = ST_ARB;
      default:   state_nxt = ST_INIT;
    endcase
  end

  // PHT port drive for the current state.
  always_comb begin
    en_c    = 1'b0;
    we_c    = 1'b0;
    addr_c  = '0;
    wdata_c = 2'b00;
    case (state)
      ST_INIT: begin
        en_c    = 1'b1;
        we_c    = 1'b1;
        addr_c  = init_cnt;
        wdata_c = 2'b01;
      end
      ST_ARB: begin
        if (pop) begin
          en_c   = 1'b1;
          addr_c = head.idx;
        end else if (grant) begin
          en_c   = 1'b1;
          addr_c = lk_idx;
        end
      end
      ST_UPD_WR: begin
        en_c    = 1'b1;
        we_c    = 1'b1;
        addr_c  = held.idx;
        wdata_c = sat_val;
      end
      default: ;
    endcase
  end

  // Saturating 2-bit counter step applied to the value read in the previous cycle.
  always_comb begin
    sat_val = tbl_rdata;
    if (held.taken) begin
      if (tbl_rdata != 2'b11) sat_val = tbl_rdata + 2'b01;
    end else begin
      if (tbl_rdata != 2'b00) sat_val = tbl_rdata - 2'b01;
    end
  end

  // Init sweep address, advancing once per INIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 init_cnt <= '0;
    else if (state == ST_INIT)  init_cnt <= init_cnt + 1'b1;
  end

  // Global history shifts in the resolved direction of every accepted update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ghr <= '0;
    else if (push) ghr <= {ghr[IDX_W-2:0], up_taken};
  end

  // Queue pointers and occupancy; pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Queue storage; entries hash with the pre-shift GHR.
  always_ff @(posedge clk) begin
    if (push) queue[wr_ptr] <= '{idx: up_idx, taken: up_taken};
  end

  // Hold the popped entry for the write half of the read-modify-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   held <= '0;
    else if (pop) held <= head;
  end

  // Count lookup grants that bypassed a waiting update; never exceeds STARVE_MAX since that forces a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               starve_cnt <= '0;
    else if (pop || q_empty)  starve_cnt <= '0;
    else if (grant)           starve_cnt <= starve_cnt + 1'b1;
  end

  // Prediction becomes valid the cycle the granted read data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_vld_q <= 1'b0;
    else        rsp_vld_q <= grant;
  end

endmodule

// File: tb/tb_bp_table_arbiter.sv
// tb_bp_table_arbiter: drives lookups/updates against a behavioural PHT scheduler model and an SRAM model.
// Latency: model predicts port activity per cycle and prediction one cycle after each grant.
// Backpressure: model tracks pending updates as a queue and enforces the starvation/full-queue priority rules.
module tb_bp_table_arbiter;

  localparam int IDX_W      = 6;
  localparam int QDEPTH     = 4;
  localparam int STARVE_MAX = 3;
  localparam int NENT       = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lk_valid = 1'b0;
  logic [31:0]      lk_pc = '0;
  logic             lk_ready;
  logic             rsp_valid, rsp_taken;
  logic             up_valid = 1'b0;
  logic [31:0]      up_pc = '0;
  logic             up_taken = 1'b0;
  logic             up_ready;
  logic             tbl_en, tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_wdata;
  logic [1:0]       tbl_rdata = 2'b00;

  int checks = 0;
  int errors = 0;

  bp_table_arbiter #(.IDX_W(IDX_W), .QDEPTH(QDEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_ready(lk_ready),
    .rsp_valid(rsp_valid), .rsp_taken(rsp_taken),
    .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_ready(up_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .tbl_rdata(tbl_rdata)
  );

  always #5 clk = ~clk;

  // Single-port PHT SRAM: read data appears the cycle after the read.
  logic [1:0] mem [NENT];
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata <= mem[tbl_addr];
    end
  end

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             tkn;
  } ent_t;

  int               m_init_addr;
  bit               m_wr_pend;
  bit [IDX_W-1:0]   m_wr_idx;
  bit               m_wr_tkn;
  ent_t             m_q[$];
  bit [IDX_W-1:0]   m_ghr;
  int               m_starve;
  bit [1:0]         m_tbl [NENT];
  bit               m_rsp_pend, m_rsp_bit;

  bit               e_lk_ready, e_up_ready, e_en, e_we, e_upd_rd, e_rsp_valid, e_rsp_taken;
  bit [IDX_W-1:0]   e_addr, e_lk_idx;
  bit [1:0]         e_wdata;

  function automatic bit [1:0] sat(input bit [1:0] c, input bit t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic model_reset();
    m_init_addr = 0;
    m_wr_pend   = 0;
    m_q.delete();
    m_ghr       = '0;
    m_starve    = 0;
    m_rsp_pend  = 0;
    m_rsp_bit   = 0;
  endtask

  // What the port and handshakes should do this cycle, given current inputs.
  task automatic model_eval();
    e_lk_idx    = lk_pc[IDX_W+1:2] ^ m_ghr;
    e_lk_ready  = 0; e_upd_rd = 0; e_en = 0; e_we = 0; e_addr = '0; e_wdata = 2'b00; e_up_ready = 0;
    e_rsp_valid = m_rsp_pend;
    e_rsp_taken = m_rsp_pend & m_rsp_bit;
    if (m_init_addr < NENT) begin
      e_en = 1; e_we = 1; e_addr = IDX_W'(m_init_addr); e_wdata = 2'b01;
    end else begin
      e_up_ready = (m_q.size() < QDEPTH);
      if (m_wr_pend) begin
        e_en = 1; e_we = 1; e_addr = m_wr_idx; e_wdata = sat(m_tbl[m_wr_idx], m_wr_tkn);
      end else if (m_q.size() > 0 && (!lk_valid || m_starve == STARVE_MAX || m_q.size() == QDEPTH)) begin
        e_upd_rd = 1; e_en = 1; e_addr = m_q[0].idx;
      end else if (lk_valid) begin
        e_lk_ready = 1; e_en = 1; e_addr = e_lk_idx;
      end
    end
  endtask

  // Advance the model across the rising edge.
  task automatic model_commit();
    ent_t e;
    m_rsp_pend = e_lk_ready;
    m_rsp_bit  = m_tbl[e_lk_idx][1];
    if (m_init_addr < NENT) begin
      m_tbl[m_init_addr] = 2'b01;
      m_init_addr++;
    end else begin
      if (m_wr_pend) begin
        m_tbl[m_wr_idx] = e_wdata;
        m_wr_pend = 0;
      end
      if (m_q.size() == 0 || e_upd_rd) m_starve = 0;
      else if (e_lk_ready)             m_starve++;
      if (e_upd_rd) begin
        m_wr_idx  = m_q[0].idx;
        m_wr_tkn  = m_q[0].tkn;
        m_wr_pend = 1;
        void'(m_q.pop_front());
      end
      if (up_valid && e_up_ready) begin
        e.idx = up_pc[IDX_W+1:2] ^ m_ghr;
        e.tkn = up_taken;
        m_q.push_back(e);
        m_ghr = {m_ghr[IDX_W-2:0], up_taken};
      end
    end
  endtask

  task automatic half_eval();
    @(negedge clk);
    model_eval();
  endtask

  task automatic half_commit();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  function automatic logic [31:0] pc_for_idx0();
    return 32'(m_ghr) << 2;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({lk_ready, rsp_valid, rsp_taken, up_ready, tbl_en, tbl_we} !== 6'b0 || tbl_addr !== '0 || tbl_wdata !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs got lk_ready/rsp_v/rsp_t/up_ready/en/we=%b addr=%0d wdata=%0d required all 0",
               {lk_ready, rsp_valid, rsp_taken, up_ready, tbl_en, tbl_we}, tbl_addr, tbl_wdata);
    end
  endtask

  // Release reset and check the 64-entry init sweep; inputs toggle to prove they are ignored.
  task automatic test_init();
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < NENT; k++) begin
      lk_valid = $urandom_range(0, 1); lk_pc = $urandom();
      up_valid = $urandom_range(0, 1); up_pc = $urandom(); up_taken = $urandom_range(0, 1);
      half_eval();
      checks++;
      if (tbl_en !== 1'b1 || tbl_we !== 1'b1 || tbl_addr !== IDX_W'(k) || tbl_wdata !== 2'b01) begin
        errors++;
        $display("FAIL init_write k=%0d got en=%b we=%b addr=%0d wdata=%0d required 1 1 %0d 1", k, tbl_en, tbl_we, tbl_addr, tbl_wdata, k);
      end
      checks++;
      if (lk_ready !== 1'b0 || up_ready !== 1'b0) begin
        errors++;
        $display("FAIL init_ready k=%0d got lk_ready=%b up_ready=%b required 0 0", k, lk_ready, up_ready);
      end
      half_commit();
    end
    lk_valid = 0; up_valid = 0;
  endtask

  task automatic test_first_lookup();
    lk_valid = 1; lk_pc = 32'd1024;
    half_eval();
    checks++;
    if (lk_ready !== 1'b1 || tbl_en !== 1'b1 || tbl_we !== 1'b0 || tbl_addr !== 6'd0) begin
      errors++;
      $display("FAIL first_lookup got lk_ready=%b en=%b we=%b addr=%0d required 1 1 0 0", lk_ready, tbl_en, tbl_we, tbl_addr);
    end
    half_commit();
    lk_valid = 0;
    half_eval();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_taken !== 1'b0) begin
      errors++;
      $display("FAIL first_rsp got valid=%b taken=%b required 1 0", rsp_valid, rsp_taken);
    end
    half_commit();
  endtask

  task automatic test_update_lookup();
    bit [1:0] got;
    up_valid = 1; up_pc = 32'd1024; up_taken = 1; lk_valid = 0;
    half_eval();
    checks++;
    if (up_ready !== 1'b1 || tbl_en !== 1'b0) begin
      errors++;
      $display("FAIL upd_accept got up_ready=%b en=%b required 1 0", up_ready, tbl_en);
    end
    half_commit();
    up_valid = 0;
    half_eval();
    checks++;
    if (tbl_en !== 1'b1 || tbl_we !== 1'b0 || tbl_addr !== 6'd0 || lk_ready !== 1'b0) begin
      errors++;
      $display("FAIL upd_read got en=%b we=%b addr=%0d lk_ready=%b required 1 0 0 0", tbl_en, tbl_we, tbl_addr, lk_ready);
    end
    half_commit();
    half_eval();
    checks++;
    if (tbl_we !== 1'b1 || tbl_addr !== 6'd0 || tbl_wdata !== 2'b10) begin
      errors++;
      $display("FAIL upd_write got we=%b addr=%0d wdata=%0d required 1 0 2", tbl_we, tbl_addr, tbl_wdata);
    end
    half_commit();
    lk_valid = 1; lk_pc = 32'd1024;
    half_eval();
    checks++;
    if (lk_ready !== 1'b1 || tbl_addr !== 6'd1) begin
      errors++;
      $display("FAIL ghr_lookup_1024 got lk_ready=%b addr=%0d required 1 1", lk_ready, tbl_addr);
    end
    half_commit();
    lk_pc = 32'd1028;
    half_eval();
    got = {rsp_valid, rsp_taken};
    checks++;
    if (got !== 2'b10 || tbl_addr !== 6'd0) begin
      errors++;
      $display("FAIL ghr_lookup_1028 got rsp=%b addr=%0d required rsp=10 addr=0", got, tbl_addr);
    end
    half_commit();
    lk_valid = 0;
    half_eval();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_taken !== 1'b1) begin
      errors++;
      $display("FAIL trained_rsp got valid=%b taken=%b required 1 1", rsp_valid, rsp_taken);
    end
    half_commit();
  endtask

  // Continuous lookups with one update: three bypassing grants, two blocked cycles, then lookups resume.
  task automatic test_starvation();
    bit [9:0] pat;
    bit [9:0] exp_pat;
    exp_pat = 10'b1111001111;
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      lk_valid = 1; lk_pc = $urandom();
      up_valid = (i == 0); up_pc = $urandom(); up_taken = $urandom_range(0, 1);
      half_eval();
      pat[i] = lk_ready;
      checks++;
      if (lk_ready !== e_lk_ready || tbl_en !== e_en || (e_en && (tbl_we !== e_we || tbl_addr !== e_addr))) begin
        errors++;
        $display("FAIL starve_cycle i=%0d got lk_ready=%b en=%b we=%b addr=%0d required %b %b %b %0d",
                 i, lk_ready, tbl_en, tbl_we, tbl_addr, e_lk_ready, e_en, e_we, e_addr);
      end
      half_commit();
    end
    checks++;
    if (pat !== exp_pat) begin
      errors++;
      $display("FAIL starve_pattern got %b required %b", pat, exp_pat);
    end
    lk_valid = 0; up_valid = 0;
  endtask

  // Drive updates aimed at index 0 until n are accepted, then drain; returns last value written to index 0.
  task automatic run_idx0_updates(input bit tkn, input bit lk_on, input int n, output bit [1:0] last_wd0);
    int acc, budget;
    acc = 0; budget = 0; last_wd0 = 2'bxx;
    while ((acc < n || m_q.size() > 0 || m_wr_pend) && budget < 60) begin
      lk_valid = lk_on && (acc < n); lk_pc = $urandom();
      up_valid = (acc < n); up_pc = pc_for_idx0(); up_taken = tkn;
      half_eval();
      if (up_valid && e_up_ready) acc++;
      if (tbl_en && tbl_we && tbl_addr == 6'd0) last_wd0 = tbl_wdata;
      checks++;
      if (up_ready !== e_up_ready || lk_ready !== e_lk_ready || tbl_en !== e_en ||
          (e_en && (tbl_we !== e_we || tbl_addr !== e_addr)) || (e_we && tbl_wdata !== e_wdata)) begin
        errors++;
        $display("FAIL idx0_upd cyc=%0d got up_rdy=%b lk_rdy=%b en=%b we=%b addr=%0d wd=%0d required %b %b %b %b %0d %0d",
                 budget, up_ready, lk_ready, tbl_en, tbl_we, tbl_addr, tbl_wdata, e_up_ready, e_lk_ready, e_en, e_we, e_addr, e_wdata);
      end
      half_commit();
      budget++;
    end
    checks++;
    if (budget >= 60) begin
      errors++;
      $display("FAIL idx0_upd_timeout accepted=%0d required %0d within 60 cycles", acc, n);
    end
    lk_valid = 0; up_valid = 0;
  endtask

  // Queue fill under lookup pressure, then counter saturation at both ends.
  task automatic test_full_and_saturation();
    bit [1:0] wd;
    for (int i = 0; i < 5; i++) begin
      lk_valid = 1; lk_pc = $urandom();
      up_valid = (i < 4); up_pc = pc_for_idx0(); up_taken = 1;
      half_eval();
      if (i == 4) begin
        checks++;
        if (up_ready !== 1'b0 || lk_ready !== 1'b0 || tbl_en !== 1'b1 || tbl_we !== 1'b0 || tbl_addr !== 6'd0) begin
          errors++;
          $display("FAIL full_queue got up_ready=%b lk_ready=%b en=%b we=%b addr=%0d required 0 0 1 0 0",
                   up_ready, lk_ready, tbl_en, tbl_we, tbl_addr);
        end
      end else begin
        checks++;
        if (up_ready !== 1'b1 || lk_ready !== 1'b1) begin
          errors++;
          $display("FAIL fill_queue i=%0d got up_ready=%b lk_ready=%b required 1 1", i, up_ready, lk_ready);
        end
      end
      half_commit();
    end
    run_idx0_updates(1'b1, 1'b1, 0, wd);
    run_idx0_updates(1'b1, 1'b0, 3, wd);
    checks++;
    if (wd !== 2'd3) begin
      errors++;
      $display("FAIL sat_high got %0d required 3", wd);
    end
    run_idx0_updates(1'b0, 1'b1, 5, wd);
    checks++;
    if (wd !== 2'd0) begin
      errors++;
      $display("FAIL sat_low got %0d required 0", wd);
    end
  endtask

  task automatic test_random(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      lk_valid = ($urandom_range(0, 3) != 0); lk_pc = $urandom();
      up_valid = ($urandom_range(0, 2) == 0); up_pc = $urandom(); up_taken = $urandom_range(0, 1);
      half_eval();
      checks++;
      if (lk_ready !== e_lk_ready || up_ready !== e_up_ready) begin
        errors++;
        $display("FAIL rnd_ready cyc=%0d got lk=%b up=%b required %b %b", i, lk_ready, up_ready, e_lk_ready, e_up_ready);
      end
      checks++;
      if (tbl_en !== e_en || (e_en && (tbl_we !== e_we || tbl_addr !== e_addr)) || (e_we && tbl_wdata !== e_wdata)) begin
        errors++;
        $display("FAIL rnd_port cyc=%0d got en=%b we=%b addr=%0d wd=%0d required %b %b %0d %0d",
                 i, tbl_en, tbl_we, tbl_addr, tbl_wdata, e_en, e_we, e_addr, e_wdata);
      end
      checks++;
      if (rsp_valid !== e_rsp_valid || rsp_taken !== e_rsp_taken) begin
        errors++;
        $display("FAIL rnd_rsp cyc=%0d got v=%b t=%b required %b %b", i, rsp_valid, rsp_taken, e_rsp_valid, e_rsp_taken);
      end
      half_commit();
    end
    lk_valid = 0; up_valid = 0;
  endtask

  // Reset asserted in the middle of an update write.
  task automatic test_reset_mid_write();
    int budget;
    bit [1:0] wd;
    run_idx0_updates(1'b1, 1'b0, 0, wd);
    up_valid = 1; up_pc = $urandom(); up_taken = 1; lk_valid = 0;
    half_eval();
    half_commit();
    up_valid = 1; up_taken = 0;
    budget = 0;
    half_eval();
    while (!(e_we && m_wr_pend) && budget < 10) begin
      half_commit();
      half_eval();
      budget++;
    end
    checks++;
    if (tbl_we !== 1'b1 || budget >= 10) begin
      errors++;
      $display("FAIL midrst_reach_write got we=%b after %0d cycles required 1", tbl_we, budget);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tbl_we, tbl_en, lk_ready, up_ready, rsp_valid, rsp_taken} !== 6'b0) begin
      errors++;
      $display("FAIL midrst_drop got we/en/lk_rdy/up_rdy/rsp_v/rsp_t=%b required 000000",
               {tbl_we, tbl_en, lk_ready, up_ready, rsp_valid, rsp_taken});
    end
    up_valid = 0;
    @(posedge clk); #1;
    test_init();
    lk_valid = 1; lk_pc = 32'd0;
    half_eval();
    checks++;
    if (lk_ready !== 1'b1 || tbl_addr !== 6'd0 || up_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_clean got lk_ready=%b addr=%0d up_ready=%b required 1 0 1", lk_ready, tbl_addr, up_ready);
    end
    half_commit();
    lk_valid = 0;
    half_eval();
    checks++;
    if (tbl_en !== 1'b0) begin
      errors++;
      $display("FAIL midrst_queue_empty got en=%b required 0", tbl_en);
    end
    half_commit();
  endtask

  initial begin
    for (int i = 0; i < NENT; i++) mem[i] = 2'($urandom_range(0, 3));
    test_reset();
    test_init();
    test_first_lookup();
    test_update_lookup();
    test_starvation();
    test_full_and_saturation();
    test_random(1500);
    test_reset_mid_write();
    test_random(500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not complete within 400000 time units");
    $fatal(1);
  end

endmodule
